dac_sample_feeder: RTL and testbench
====================================

Name: dac_sample_feeder

Overview:
- Upstream stage of the SPI DAC output controller: buffers 12-bit audio samples from the synthesis path and releases exactly one per sample period (default 22050 Hz) over the controller's sendSample_n / isBusy handshake.
- Contains a 16-entry sample FIFO, a sample-rate tick divider and a request/handshake FSM.
- Includes underrun, missed-tick and timeout reporting.

Parameters:
- TICK_DIVISOR, 2268, clock_50Mhz cycles per sample period (50e6/22050, rounded).
- FIFO_DEPTH, 16, sample FIFO entries; must be a power of two.
- REQ_TIMEOUT, 256, maximum cycles in REQUEST before abort.
- IDLE_SAMPLE, 12'h800, dac_sample value at reset and the repeat value before any sample has been sent.

Ports:
- clock_50Mhz  in  1  system clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  permits new DAC requests.
- in_sample  in  12  sample from the producer.
- in_valid  in  1  in_sample valid.
- in_ready  out  1  FIFO can accept; push occurs when in_valid & in_ready.
- dac_sample  out  12  to controller inputSample.
- dac_sendSample_n  out  1  to controller sendSample_n; active low.
- dac_isBusy  in  1  from controller isBusy; generated on the DAC-side clock.
- fifo_level  out  5  current FIFO occupancy, 0..16.
- underrun_pulse  out  1  one-cycle pulse when a tick finds the FIFO empty.
- missed_tick_pulse  out  1  one-cycle pulse when a tick arrives while not IDLE.
- timeout_pulse  out  1  one-cycle pulse when a REQUEST is aborted.

Behaviour:

Reset (synchronous, active-high):
- FIFO is emptied: fifo_level=0, in_ready=1.
- Tick counter=0; state=IDLE.
- dac_sample=IDLE_SAMPLE; dac_sendSample_n=1.
- All pulse outputs=0; synchronizer flops=0.
- Asserting reset mid-transfer drops the request immediately: dac_sendSample_n=1 on the next edge.

Tick divider:
- Counter runs 0..TICK_DIVISOR-1 while enable=1; tick=1 for the single cycle where count==TICK_DIVISOR-1, then wraps to 0.
- enable=0 holds the counter at 0.

FIFO:
- in_ready = (level != FIFO_DEPTH). When full, in_ready=0 even if a pop occurs in the same cycle.
- A push and a pop in the same cycle (not full, not empty) leave the level unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH; the extra level bit distinguishes full from empty.

isBusy synchronizer:
- dac_isBusy passes through a 2-flop synchronizer; the result is busy_s. All FSM decisions use busy_s.

FSM states:
- IDLE: on tick with enable=1, at the next edge:
  - dac_sample <= FIFO head and pop if level>0; otherwise dac_sample keeps its last value (IDLE_SAMPLE if no sample has been sent yet) and underrun_pulse=1.
  - dac_sendSample_n <= 0; timeout counter cleared; go to REQUEST.
- REQUEST: dac_sendSample_n held 0 and dac_sample held stable.
  - busy_s=1: set dac_sendSample_n<=1 and go to WAIT_DONE.
  - Timeout counter reaches REQ_TIMEOUT-1: set dac_sendSample_n<=1, timeout_pulse=1, go to IDLE. The popped sample is discarded.
- WAIT_DONE: dac_sample held stable. busy_s=0 → IDLE.
- A tick in REQUEST or WAIT_DONE produces missed_tick_pulse=1 and no other effect; ticks are never queued.
- enable falling mid-transfer does not abort; the current transfer completes, then the FSM stays in IDLE.

Latency:
- Tick to dac_sendSample_n low: 1 cycle.
- dac_sample changes only on the IDLE→REQUEST edge.

Decomposition:
- Shared package dac_feeder_pkg:
  - typedef sample_t (logic [11:0]).
  - enum feeder_state_t {IDLE, REQUEST, WAIT_DONE}.
  - constants SAMPLE_MIDSCALE=12'h800 and DEFAULT_TICK_DIVISOR=2268.
- Sub-module sample_fifo (parameter DEPTH; ports: clock_50Mhz, reset, push, push_data, pop, head_data, level, full, empty).
- Divider, synchronizer and FSM remain in the top module.

Test Plan:
- Reset, then push 0x123, 0x456, 0x789; model the controller with busy rising 80 cycles after the request and falling 1500 cycles later → dac_sample takes 0x123, 0x456, 0x789 on successive ticks 2268 cycles apart; fifo_level ends at 0; no pulses.
- Reset with the FIFO empty, enable=1 → first tick gives dac_sample=0x800, underrun_pulse once, and a full handshake completes. Then push 0xABC and send one tick → output 0xABC. Then one empty tick → 0xABC repeated with underrun_pulse.
- Push 17 samples back-to-back with enable=0 → in_ready drops after the 16th push; the 17th is not accepted; fifo_level=16.
- Model holds busy=1 for 3000 cycles → the tick during WAIT_DONE gives missed_tick_pulse=1 and no new request; the next tick after busy falls issues a request normally.
- Model never asserts busy → dac_sendSample_n is low for exactly 256 cycles, then timeout_pulse=1, state returns to IDLE, and fifo_level has decremented by 1.
- Assert reset for 1 cycle while in REQUEST → next edge: dac_sendSample_n=1, fifo_level=0, dac_sample=0x800.

Source files
------------

// File: rtl/dac_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dac_feeder_pkg
// Description : Shared types and constants for the DAC sample feeder slice.
//               sample_t        - 12-bit DAC sample word
//               feeder_state_t  - request/handshake FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package dac_feeder_pkg;

    typedef logic [11:0] sample_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQUEST   = 2'd1,
        WAIT_DONE = 2'd2
    } feeder_state_t;

    localparam sample_t SAMPLE_MIDSCALE      = 12'h800;
    localparam int      DEFAULT_TICK_DIVISOR = 2268;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Synchronous sample FIFO, DEPTH entries (power of two).
//               Pointers carry one extra bit so full and empty are distinct.
// Ports       : clock_50Mhz, reset (sync, active high)
//               push/push_data - write side (ignored when full)
//               pop            - read side (ignored when empty)
//               head_data      - oldest entry, valid when !empty
//               level          - occupancy 0..DEPTH
//               full, empty    - status flags
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo
    import dac_feeder_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clock_50Mhz,
    input  logic                   reset,
    input  logic                   push,
    input  sample_t                push_data,
    input  logic                   pop,
    output sample_t                head_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int c_AW = $clog2(DEPTH);

    sample_t         r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic            w_do_push;
    logic            w_do_pop;

    // Same low bits with differing wrap bits means the writer is a full lap ahead.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign level = r_wr_ptr - r_rd_ptr;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign head_data = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
            end
        end
    end

    // Storage needs no reset; pointers alone define which entries are live.
    always_ff @(posedge clock_50Mhz) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dac_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : dac_sample_feeder
// Description : Buffers 12-bit samples and releases one per sample period to
//               the SPI DAC controller over the sendSample_n/isBusy handshake.
// Ports       : clock_50Mhz, reset (sync, active high), enable
//               in_sample/in_valid/in_ready - producer push interface
//               dac_sample, dac_sendSample_n - to controller (request low)
//               dac_isBusy                   - from controller (async domain)
//               fifo_level                   - FIFO occupancy 0..FIFO_DEPTH
//               underrun_pulse, missed_tick_pulse, timeout_pulse - events
// Revision    : 1.0 - initial release
// ============================================================================
module dac_sample_feeder
    import dac_feeder_pkg::*;
#(
    parameter int      TICK_DIVISOR = DEFAULT_TICK_DIVISOR,
    parameter int      FIFO_DEPTH   = 16,
    parameter int      REQ_TIMEOUT  = 256,
    parameter sample_t IDLE_SAMPLE  = SAMPLE_MIDSCALE
) (
    input  logic                        clock_50Mhz,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [11:0]                 in_sample,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [11:0]                 dac_sample,
    output logic                        dac_sendSample_n,
    input  logic                        dac_isBusy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underrun_pulse,
    output logic                        missed_tick_pulse,
    output logic                        timeout_pulse
);

    localparam int c_TICK_W = $clog2(TICK_DIVISOR);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIVISOR - 1);
    localparam int c_TO_W = $clog2(REQ_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(REQ_TIMEOUT - 1);

    // ---------------------------------------------------------------- FIFO
    sample_t w_head;
    logic    w_full;
    logic    w_empty;
    logic    w_push;
    logic    w_pop;

    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_50Mhz (clock_50Mhz),
        .reset       (reset),
        .push        (w_push),
        .push_data   (in_sample),
        .pop         (w_pop),
        .head_data   (w_head),
        .level       (fifo_level),
        .full        (w_full),
        .empty       (w_empty)
    );

    // -------------------------------------------------------- tick divider
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                w_tick;

    assign w_tick = enable && (r_tick_cnt == c_TICK_LAST);

    always_ff @(posedge clock_50Mhz) begin
        if (reset || !enable || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
        end
    end

    // ------------------------------------------------- isBusy synchronizer
    logic r_busy_meta;
    logic r_busy_s;

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            r_busy_meta <= 1'b0;
            r_busy_s    <= 1'b0;
        end else begin
            r_busy_meta <= dac_isBusy;
            r_busy_s    <= r_busy_meta;
        end
    end

    // ----------------------------------------------------------------- FSM
    feeder_state_t     r_state;
    feeder_state_t     w_state_next;
    sample_t           r_sample;
    sample_t           w_sample_next;
    logic              r_send_n;
    logic              w_send_n_next;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [c_TO_W-1:0] w_to_cnt_next;
    logic              r_underrun;
    logic              w_underrun_next;
    logic              r_missed;
    logic              w_missed_next;
    logic              r_timeout;
    logic              w_timeout_next;

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sample   <= IDLE_SAMPLE;
            r_send_n   <= 1'b1;
            r_to_cnt   <= '0;
            r_underrun <= 1'b0;
            r_missed   <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sample   <= w_sample_next;
            r_send_n   <= w_send_n_next;
            r_to_cnt   <= w_to_cnt_next;
            r_underrun <= w_underrun_next;
            r_missed   <= w_missed_next;
            r_timeout  <= w_timeout_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_sample_next   = r_sample;
        w_send_n_next   = r_send_n;
        w_to_cnt_next   = r_to_cnt;
        w_pop           = 1'b0;
        w_underrun_next = 1'b0;
        w_missed_next   = 1'b0;
        w_timeout_next  = 1'b0;

        case (r_state)
            IDLE: begin
                // w_tick already implies enable, so a disabled feeder parks here.
                if (w_tick) begin
                    if (!w_empty) begin
                        w_sample_next = w_head;
                        w_pop         = 1'b1;
                    end else begin
                        // Repeat the last sample so the DAC output holds steady.
                        w_underrun_next = 1'b1;
                    end
                    w_send_n_next = 1'b0;
                    w_to_cnt_next = '0;
                    w_state_next  = REQUEST;
                end
            end

            REQUEST: begin
                w_missed_next = w_tick;
                if (r_busy_s) begin
                    w_send_n_next = 1'b1;
                    w_state_next  = WAIT_DONE;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_send_n_next  = 1'b1;
                    w_timeout_next = 1'b1;
                    w_state_next   = IDLE;
                end else begin
                    w_to_cnt_next = r_to_cnt + c_TO_W'(1);
                end
            end

            WAIT_DONE: begin
                w_missed_next = w_tick;
                if (!r_busy_s) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_send_n_next = 1'b1;
                w_state_next  = IDLE;
            end
        endcase
    end

    assign dac_sample        = r_sample;
    assign dac_sendSample_n  = r_send_n;
    assign underrun_pulse    = r_underrun;
    assign missed_tick_pulse = r_missed;
    assign timeout_pulse     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_sample_feeder
// Description : Self-checking bench for dac_sample_feeder. Expected samples are
//               queued at stimulus time; a monitor pops one per request edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_sample_feeder;

    localparam int c_DIV = 2268;

    logic        clock_50Mhz = 1'b0;
    logic        reset       = 1'b1;
    logic        enable      = 1'b0;
    logic [11:0] in_sample   = '0;
    logic        in_valid    = 1'b0;
    logic        dac_isBusy  = 1'b0;
    logic        in_ready;
    logic [11:0] dac_sample;
    logic        dac_sendSample_n;
    logic [4:0]  fifo_level;
    logic        underrun_pulse;
    logic        missed_tick_pulse;
    logic        timeout_pulse;

    dac_sample_feeder u_dut (
        .clock_50Mhz       (clock_50Mhz),
        .reset             (reset),
        .enable            (enable),
        .in_sample         (in_sample),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .dac_sample        (dac_sample),
        .dac_sendSample_n  (dac_sendSample_n),
        .dac_isBusy        (dac_isBusy),
        .fifo_level        (fifo_level),
        .underrun_pulse    (underrun_pulse),
        .missed_tick_pulse (missed_tick_pulse),
        .timeout_pulse     (timeout_pulse)
    );

    always #10 clock_50Mhz = ~clock_50Mhz;

    int          checks      = 0;
    int          failures    = 0;
    int          cyc         = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mon_exp;
    int          req_count   = 0;
    int          under_cnt   = 0;
    int          missed_cnt  = 0;
    int          timeout_cnt = 0;
    int          low_run     = 0;
    int          last_low_len = 0;
    int          last_req_cyc = 0;
    bit          check_intervals = 1'b0;
    bit          model_on    = 1'b0;
    int          model_rise  = 80;
    int          model_hold  = 1500;
    logic        prev_send_n = 1'b1;

    always @(posedge clock_50Mhz) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every falling edge of sendSample_n is one presented sample.
    always @(negedge clock_50Mhz) begin
        if (underrun_pulse === 1'b1)    under_cnt++;
        if (missed_tick_pulse === 1'b1) missed_cnt++;
        if (timeout_pulse === 1'b1)     timeout_cnt++;
        if (dac_sendSample_n === 1'b0) begin
            low_run++;
        end else if (prev_send_n === 1'b0) begin
            last_low_len = low_run;
            low_run      = 0;
        end
        if (prev_send_n === 1'b1 && dac_sendSample_n === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_request: actual sample=0x%0h expected no request", dac_sample);
            end else begin
                mon_exp = exp_q.pop_front();
                check("req_sample", {20'd0, dac_sample}, {20'd0, mon_exp});
            end
            if (check_intervals && req_count > 0) begin
                check("tick_interval", cyc - last_req_cyc, c_DIV);
            end
            last_req_cyc = cyc;
            req_count++;
        end
        prev_send_n = dac_sendSample_n;
    end

    // Controller model: busy rises model_rise cycles after a request, holds model_hold.
    initial begin
        forever begin
            @(negedge clock_50Mhz);
            if (model_on && dac_sendSample_n === 1'b0) begin
                repeat (model_rise) @(posedge clock_50Mhz);
                #1 dac_isBusy = 1'b1;
                repeat (model_hold) @(posedge clock_50Mhz);
                #1 dac_isBusy = 1'b0;
            end
        end
    end

    task automatic clear_counts();
        req_count   = 0;
        under_cnt   = 0;
        missed_cnt  = 0;
        timeout_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clock_50Mhz);
        reset = 1'b1;
        @(negedge clock_50Mhz);
        reset = 1'b0;
        clear_counts();
    endtask

    task automatic push_one(input logic [11:0] d, output bit acc);
        @(negedge clock_50Mhz);
        in_sample = d;
        in_valid  = 1'b1;
        acc       = in_ready;
    endtask

    task automatic push_end();
        @(negedge clock_50Mhz);
        in_valid = 1'b0;
    endtask

    task automatic wait_reqs(input int n, input int budget, input string name);
        int i;
        i = 0;
        while (req_count < n && i < budget) begin
            @(negedge clock_50Mhz);
            i++;
        end
        if (req_count < n) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: actual requests=%0d required=%0d", name, req_count, n);
        end
    endtask

    initial begin
        bit acc;
        int acc_total;

        #(2_000_000);
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        int acc_total;

        // ---- reset state
        repeat (3) @(negedge clock_50Mhz);
        reset = 1'b0;
        check("rst_level", fifo_level, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sample", dac_sample, 12'h800);
        check("rst_send_n", dac_sendSample_n, 1);
        check("rst_pulses", {underrun_pulse, missed_tick_pulse, timeout_pulse}, 0);

        // ---- three samples on three successive ticks
        do_reset();
        push_one(12'h123, acc); push_one(12'h456, acc); push_one(12'h789, acc); push_end();
        exp_q.push_back(12'h123); exp_q.push_back(12'h456); exp_q.push_back(12'h789);
        check("t1_level_loaded", fifo_level, 3);
        model_rise = 80; model_hold = 1500; model_on = 1'b1;
        check_intervals = 1'b1;
        enable = 1'b1;
        wait_reqs(3, 3 * c_DIV + 500, "t1");
        repeat (1700) @(negedge clock_50Mhz);
        enable = 1'b0;
        check_intervals = 1'b0;
        check("t1_level_end", fifo_level, 0);
        check("t1_send_n_idle", dac_sendSample_n, 1);
        check("t1_underrun", under_cnt, 0);
        check("t1_missed", missed_cnt, 0);
        check("t1_timeout", timeout_cnt, 0);

        // ---- underrun on empty FIFO, then real sample, then repeat
        do_reset();
        exp_q.push_back(12'h800);
        enable = 1'b1;
        wait_reqs(1, c_DIV + 400, "t2a");
        repeat (1700) @(negedge clock_50Mhz);
        check("t2_handshake_done", dac_sendSample_n, 1);
        check("t2_underrun_first", under_cnt, 1);
        push_one(12'hABC, acc); push_end();
        exp_q.push_back(12'hABC);
        wait_reqs(2, c_DIV + 400, "t2b");
        repeat (5) @(negedge clock_50Mhz);
        check("t2_no_underrun_with_data", under_cnt, 1);
        exp_q.push_back(12'hABC);
        wait_reqs(3, c_DIV + 400, "t2c");
        repeat (5) @(negedge clock_50Mhz);
        check("t2_underrun_repeat", under_cnt, 2);
        repeat (1700) @(negedge clock_50Mhz);
        enable = 1'b0;
        check("t2_missed", missed_cnt, 0);

        // ---- fill to full
        do_reset();
        acc_total = 0;
        for (int i = 0; i < 16; i++) begin
            push_one(12'(i + 1), acc);
            acc_total += int'(acc);
        end
        push_one(12'hFFF, acc);
        check("t3_accepted_16", acc_total, 16);
        check("t3_17th_rejected", acc, 0);
        push_end();
        check("t3_level_full", fifo_level, 16);
        check("t3_in_ready_low", in_ready, 0);

        // ---- long busy: tick during WAIT_DONE is missed
        do_reset();
        push_one(12'h0A1, acc); push_one(12'h0A2, acc); push_end();
        exp_q.push_back(12'h0A1);
        model_rise = 80; model_hold = 3000; model_on = 1'b1;
        enable = 1'b1;
        wait_reqs(1, c_DIV + 400, "t4a");
        begin
            int i;
            i = 0;
            while (missed_cnt < 1 && i < c_DIV + 400) begin
                @(negedge clock_50Mhz);
                i++;
            end
        end
        check("t4_missed_seen", missed_cnt, 1);
        check("t4_no_request_on_missed", req_count, 1);
        model_hold = 1500;
        exp_q.push_back(12'h0A2);
        wait_reqs(2, 2 * c_DIV + 400, "t4b");
        repeat (1700) @(negedge clock_50Mhz);
        enable = 1'b0;
        check("t4_missed_total", missed_cnt, 1);
        check("t4_underrun", under_cnt, 0);
        check("t4_level_end", fifo_level, 0);

        // ---- controller never answers: timeout
        do_reset();
        model_on = 1'b0;
        push_one(12'h321, acc); push_one(12'h654, acc); push_end();
        exp_q.push_back(12'h321);
        enable = 1'b1;
        wait_reqs(1, c_DIV + 400, "t5");
        repeat (300) @(negedge clock_50Mhz);
        check("t5_low_cycles", last_low_len, 256);
        check("t5_timeout_pulse", timeout_cnt, 1);
        check("t5_send_n_released", dac_sendSample_n, 1);
        check("t5_level_dec", fifo_level, 1);

        // ---- reset in REQUEST drops the request immediately
        exp_q.push_back(12'h654);
        wait_reqs(2, c_DIV + 400, "t6");
        repeat (10) @(negedge clock_50Mhz);
        check("t6_in_request", dac_sendSample_n, 0);
        reset = 1'b1;
        @(negedge clock_50Mhz);
        reset  = 1'b0;
        enable = 1'b0;
        check("t6_send_n", dac_sendSample_n, 1);
        check("t6_level", fifo_level, 0);
        check("t6_sample", dac_sample, 12'h800);
        repeat (10) @(negedge clock_50Mhz);

        check("all_expected_consumed", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
